// File: rtl/spi_flash_phy.sv
// Byte-level SPI master for serial flash: chip-select framing, setup/hold/deselect timing, dclk generation.
// Build option: define SPI_FLASH_PHY_MODE3_EN for SPI mode 3 (dclk idles high); the default is mode 0.
module spi_flash_phy #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_HOLD  = 2,
    parameter int unsigned CS_IDLE  = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_byte,
    input  logic       cmd_last,
    output logic       rsp_valid,
    output logic [7:0] rsp_byte,
    output logic       busy,
    output logic       ncs,
    output logic       dclk,
    output logic       mosi,
    input  logic       miso
);

`ifdef SPI_FLASH_PHY_MODE3_EN
    localparam logic IDLE_LVL = 1'b1;
`else
    localparam logic IDLE_LVL = 1'b0;
`endif

    localparam logic [15:0] DIV_END   = 16'(CLK_DIV - 1);
    localparam logic [15:0] SETUP_END = 16'(CS_SETUP - 1);
    localparam logic [15:0] HOLD_END  = 16'(CS_HOLD - 1);
    localparam logic [15:0] DESEL_END = 16'(CS_IDLE - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, GAP, HOLD, DESEL} state_t;

    state_t      state, state_d;
    logic [15:0] cnt, cnt_d;
    logic [2:0]  bit_idx, bit_idx_d;
    logic        high, high_d;
    logic [7:0]  tx, tx_d;
    logic [7:0]  rx, rx_d;
    logic        last, last_d;
    logic        cmd_ready_d, rsp_valid_d, busy_d, ncs_d, dclk_d, mosi_d;
    logic [7:0]  rsp_byte_d;
    logic        accept;

    assign accept = cmd_valid && cmd_ready;

    always_comb begin
        state_d     = state;
        cnt_d       = cnt + 16'd1;
        bit_idx_d   = bit_idx;
        high_d      = high;
        tx_d        = tx;
        rx_d        = rx;
        last_d      = last;
        rsp_valid_d = 1'b0;
        rsp_byte_d  = rsp_byte;
        ncs_d       = ncs;
        dclk_d      = dclk;
        mosi_d      = mosi;
        case (state)
            IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    state_d = SETUP;
                    tx_d    = cmd_byte;
                    last_d  = cmd_last;
                    ncs_d   = 1'b0;
                    mosi_d  = cmd_byte[7];
                end
            end
            SETUP: begin
                if (cnt == SETUP_END) begin
                    state_d   = SHIFT;
                    cnt_d     = '0;
                    bit_idx_d = 3'd7;
                    high_d    = 1'b0;
                    dclk_d    = 1'b0;
                end
            end
            SHIFT: begin
                if (cnt == DIV_END) begin
                    cnt_d = '0;
                    if (!high) begin
                        high_d = 1'b1;
                        dclk_d = 1'b1;
                    end else begin
                        // miso is taken on the same clk edge that ends the high phase
                        rx_d = {rx[6:0], miso};
                        if (bit_idx == 3'd0) begin
                            rsp_valid_d = 1'b1;
                            rsp_byte_d  = rx_d;
                            dclk_d      = IDLE_LVL;
                            state_d     = last ? HOLD : GAP;
                        end else begin
                            bit_idx_d = bit_idx - 3'd1;
                            high_d    = 1'b0;
                            dclk_d    = 1'b0;
                            tx_d      = {tx[6:0], 1'b0};
                            mosi_d    = tx[6];
                        end
                    end
                end
            end
            GAP: begin
                cnt_d = '0;
                if (accept) begin
                    state_d   = SHIFT;
                    tx_d      = cmd_byte;
                    last_d    = cmd_last;
                    bit_idx_d = 3'd7;
                    high_d    = 1'b0;
                    dclk_d    = 1'b0;
                    mosi_d    = cmd_byte[7];
                end
            end
            HOLD: begin
                if (cnt == HOLD_END) begin
                    state_d = DESEL;
                    cnt_d   = '0;
                    ncs_d   = 1'b1;
                    mosi_d  = 1'b0;
                end
            end
            DESEL: begin
                if (cnt == DESEL_END) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        cmd_ready_d = (state_d == IDLE) || (state_d == GAP);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            high      <= 1'b0;
            tx        <= '0;
            rx        <= '0;
            last      <= 1'b0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_byte  <= '0;
            busy      <= 1'b0;
            ncs       <= 1'b1;
            dclk      <= IDLE_LVL;
            mosi      <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            bit_idx   <= bit_idx_d;
            high      <= high_d;
            tx        <= tx_d;
            rx        <= rx_d;
            last      <= last_d;
            cmd_ready <= cmd_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_byte  <= rsp_byte_d;
            busy      <= busy_d;
            ncs       <= ncs_d;
            dclk      <= dclk_d;
            mosi      <= mosi_d;
        end
    end

endmodule
